bus_sequencer: RTL

- Sequences the 8-phase instruction cycle on the shared 4-bit bus of the 4ft4 system: A1, A2, A3, M1, M2, X1, X2, X3.
- Snoops the opcode on the bus and drives the per-phase signals: sync, the ROM chip-select line, the RAM bank lines, and exactly-one-driver bus enables.
- Holds the DCL RAM bank register.
- Sits in `system` between cpu, the ROM and ram_1/ram_2; cpu keeps its datapath and pc_stack and takes phase from this block.

---
 rtl/bus_pkg.sv | 29 ++
 rtl/bus_sequencer.sv | 128 ++++++++++++
 2 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the 4ft4 bus sequencer.
//   phase_t       : the eight instruction-cycle phases, A1=0 .. X3=7
//   OPR_* / OPA_* : opcode nibbles the sequencer snoops for
//   cm_ram_decode : maps a DCL bank value onto the four RAM command lines
package bus_pkg;

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

  localparam logic [3:0] OPR_IO  = 4'hE;
  localparam logic [3:0] OPR_SRC = 4'h2;
  localparam logic [3:0] OPR_DCL = 4'hF;
  localparam logic [3:0] OPA_DCL = 4'hD;

  // Bank 0 uses the dedicated line cm_ram[0]; other banks appear
  // directly on cm_ram[3:1].
  function automatic logic [3:0] cm_ram_decode(input logic [2:0] bank);
    return {bank, (bank == 3'd0)};
  endfunction

endpackage

// File: rtl/bus_sequencer.sv
// Instruction-cycle sequencer for the shared 4-bit bus of the 4ft4 system.
// Steps through A1..X3, snoops the opcode fetched in M1/M2, holds the DCL
// RAM bank register and decodes the per-phase strobes and bus-owner enables.
//
// Ports:
//   clock        in   system clock, all state on posedge
//   reset        in   asynchronous active-low reset
//   data[3:0]    in   snoop of the shared data bus
//   second_word  in   current fetch is the 2nd word of a two-word instruction
//   accumulator  in   cpu accumulator, source for DCL
//   phase[2:0]   out  current phase, A1=0 .. X3=7 (also the FSM state)
//   sync         out  high during X3
//   cm_rom       out  ROM command/select strobe
//   cm_ram[3:0]  out  RAM bank command lines
//   cpu_drive    out  cpu owns the bus this phase
//   rom_drive    out  ROM owns the bus this phase
//   ram_drive    out  RAM owns the bus this phase
//   bank[2:0]    out  current DCL bank register
//
// Bus ownership: at most one of cpu/rom/ram_drive is high in any phase; the
// owner drives data for that whole phase and everybody else only listens.
// All outputs are decoded from registered state, never from the inputs.
module bus_sequencer
  import bus_pkg::*;
#(
  parameter logic [2:0] RESET_BANK = 3'd0,
  parameter logic [3:0] RDR_OPA    = 4'hA
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] data,
  input  logic       second_word,
  input  logic [3:0] accumulator,
  output logic [2:0] phase,
  output logic       sync,
  output logic       cm_rom,
  output logic [3:0] cm_ram,
  output logic       cpu_drive,
  output logic       rom_drive,
  output logic       ram_drive,
  output logic [2:0] bank
);

  phase_t     phase_q;
  logic [3:0] opr_q;
  logic [3:0] opa_q;
  logic       is_io_q;
  logic       is_src_q;
  logic [2:0] bank_q;

  // DCL only carries a 3-bit bank; the accumulator MSB is not needed here.
  logic unused_acc_msb;
  assign unused_acc_msb = accumulator[3];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase_q  <= PH_A1;
      opr_q    <= 4'h0;
      opa_q    <= 4'h0;
      is_io_q  <= 1'b0;
      is_src_q <= 1'b0;
      bank_q   <= RESET_BANK;
    end else begin
      phase_q <= phase_t'(phase_q + 3'd1);
      case (phase_q)
        PH_M1: begin
          // A second word is operand data, not an opcode: blank it.
          opr_q   <= second_word ? 4'h0 : data;
          is_io_q <= (data == OPR_IO) && !second_word;
        end
        PH_M2: begin
          opa_q    <= second_word ? 4'h0 : data;
          is_src_q <= (opr_q == OPR_SRC) && data[0] && !second_word;
        end
        PH_X3: begin
          if ((opr_q == OPR_DCL) && (opa_q == OPA_DCL) && !second_word)
            bank_q <= accumulator[2:0];
          is_io_q  <= 1'b0;
          is_src_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cpu_drive = 1'b0;
    rom_drive = 1'b0;
    ram_drive = 1'b0;
    cm_rom    = 1'b0;
    cm_ram    = 4'b0000;
    case (phase_q)
      PH_A1, PH_A2: cpu_drive = 1'b1;
      PH_A3: begin
        cpu_drive = 1'b1;
        cm_rom    = 1'b1;
      end
      PH_M1: rom_drive = 1'b1;
      PH_M2: begin
        rom_drive = 1'b1;
        if (is_io_q) begin
          cm_rom = 1'b1;
          cm_ram = cm_ram_decode(bank_q);
        end
      end
      PH_X2: begin
        if (is_src_q) begin
          cpu_drive = 1'b1;
          cm_rom    = 1'b1;
          cm_ram    = cm_ram_decode(bank_q);
        end else if (is_io_q) begin
          // opa 0..7 are writes (cpu sources data); RDR reads the ROM
          // port; the remaining reads come from RAM.
          if (opa_q < 4'h8)          cpu_drive = 1'b1;
          else if (opa_q == RDR_OPA) rom_drive = 1'b1;
          else                       ram_drive = 1'b1;
        end
      end
      PH_X3: cpu_drive = is_src_q;
      default: ;  // X1 is the bus turnaround phase
    endcase
  end

  assign phase = phase_q;
  assign sync  = (phase_q == PH_X3);
  assign bank  = bank_q;

endmodule
